mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns a load or store held in MEM into a req/ack transaction on the data-memory bus.
- Stalls the upstream pipeline until the bus acknowledges, then loads the MEM/WB pipeline register that feeds writeback.
- ALU-only instructions pass straight through with no stall.

Parameters:
- DATA_W, 32, data and address width.
- REG_AW, 5, register-file address width.
- TIMEOUT_CYCLES, 16, watchdog limit in cycles; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- Regfile_weM  input  1  register write enable of the instruction in MEM
- DataMem_weM  input  1  store instruction in MEM
- memReadM  input  1  load instruction in MEM
- wirteRegAddrM  input  REG_AW  destination register
- aluOutM  input  DATA_W  ALU result / effective address
- writeDataM  input  DATA_W  store data
- stallM  output  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM
- dmem_req  output  1  registered bus request
- dmem_we  output  1  registered; 1 = write
- dmem_addr  output  DATA_W  registered; {aluOutM[DATA_W-1:2],2'b00}
- dmem_wdata  output  DATA_W  registered store data
- dmem_ack  input  1  responder completion; sampled only while dmem_req=1
- dmem_rdata  input  DATA_W  read data, valid with dmem_ack
- Regfile_weW  output  1  MEM/WB register write enable
- memToRegW  output  1  1 = writeback selects readDataW
- wirteRegAddrW  output  REG_AW  MEM/WB destination register
- aluOutW  output  DATA_W  MEM/WB ALU result
- readDataW  output  DATA_W  MEM/WB load data

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst.
- Reset values: state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; all W outputs 0. stallM=0 follows from state IDLE with no memory op.
- Definition: op = memReadM | DataMem_weM. If both are 1, the access is treated as a store.
- State IDLE, op=0:
  - stallM=0.
  - MEM/WB loads Regfile_weW<=Regfile_weM, memToRegW<=0, wirteRegAddrW, aluOutW; readDataW holds.
- State IDLE, op=1:
  - stallM=1.
  - Register dmem_req<=1, dmem_we<=DataMem_weM, and dmem_addr/dmem_wdata from the MEM inputs.
  - MEM/WB receives a bubble: Regfile_weW<=0, other W fields hold.
  - Next state REQ.
- State REQ, dmem_ack=0:
  - stallM=1.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
  - Bubble into MEM/WB.
- State REQ, dmem_ack=1:
  - stallM=0 in the same cycle, so the pipeline advances.
  - dmem_req<=0; next state IDLE.
  - MEM/WB loads Regfile_weW<=Regfile_weM&~DataMem_weM, memToRegW<=memReadM&~DataMem_weM, wirteRegAddrW, aluOutW.
  - For a load, readDataW<=dmem_rdata; for a store, readDataW holds.
- Latency: minimum 2 cycles in MEM per memory op (issue cycle plus ack cycle); each extra wait state adds 1. ALU op: 1 cycle.
- Back-to-back memory ops: the second op is issued from IDLE in the cycle after the first op's ack. No combinational path from dmem_ack to dmem_req.
- dmem_ack while dmem_req=0 is ignored, with no state change.
- Exactly one bus transaction per instruction: EX/MEM is frozen by stallM, and the FSM only issues from IDLE.
- rst asserted mid-transaction (REQ): dmem_req drops on the next edge, state goes to IDLE, and the outstanding access is abandoned. A later ack is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in REQ and is cleared on entry to REQ.
  - If it reaches TIMEOUT_CYCLES without ack: stallM=0 that cycle, dmem_req<=0, state IDLE, and MEM/WB receives a bubble (Regfile_weW<=0).
  - Output port bus_errW (1 bit, reset 0) is set on that edge and stays sticky until rst.
  - An ack in the same cycle as the timeout takes priority, giving normal completion.
- Undefined: no counter and no bus_errW port; REQ waits indefinitely.

Test Plan:
- Reset/ALU pass-through: rst 2 cycles, then Regfile_weM=1, wirteRegAddrM=5'd3, aluOutM=32'h10 with op=0 -> stallM=0, no dmem_req, next edge Regfile_weW=1, wirteRegAddrW=3, aluOutW=32'h10, memToRegW=0.
- Zero-wait load: memReadM=1, aluOutM=32'h0000_0104, wirteRegAddrM=5'd8; responder acks on the first cycle req=1 with rdata=32'hDEADBEEF -> dmem_addr=32'h104, dmem_we=0, stallM=1 exactly 1 cycle, then readDataW=32'hDEADBEEF, memToRegW=1, Regfile_weW=1, wirteRegAddrW=8.
- Store with 3 wait states: DataMem_weM=1, aluOutM=32'h203, writeDataM=32'hA5A5_0001 -> dmem_addr=32'h200 and dmem_wdata held stable for 4 req cycles, dmem_we=1, stallM=1 for 4 cycles, Regfile_weW=0 throughout and after.
- Back-to-back load then store -> two separate req pulses separated by exactly one req=0 cycle; each completes in order.
- Reset mid-REQ after 2 wait cycles, then ack asserted post-reset -> dmem_req=0 and all outputs 0 one cycle after rst; the late ack causes no MEM/WB update.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, responder never acks -> req high 4 cycles, then stallM=0, bus_errW=1 (sticky), Regfile_weW=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// MEM-stage controller between the EX/MEM and MEM/WB pipeline registers.
// It turns a load or store held in MEM into one req/ack transaction on the
// data-memory bus. It stalls the upstream pipeline until the bus acknowledges,
// then loads MEM/WB. ALU-only instructions pass straight through without a
// stall.
//
// Optional build macro: MEM_TIMEOUT_EN
//   When defined, a watchdog abandons a request that is not acknowledged
//   within TIMEOUT_CYCLES cycles in REQ. The sticky bus_errW output is then
//   set. When undefined, REQ waits indefinitely and bus_errW does not exist.
//
// Ports
//   clk, rst          pipeline clock, synchronous active-high reset
//   Regfile_weM       register write enable of the instruction in MEM
//   DataMem_weM       store in MEM (wins over memReadM if both are set)
//   memReadM          load in MEM
//   wirteRegAddrM     destination register
//   aluOutM           ALU result / effective address
//   writeDataM        store data
//   stallM            combinational; freezes PC, IF/ID, ID/EX, EX/MEM
//   dmem_req/we/addr/wdata  registered bus request (addr word aligned)
//   dmem_ack          responder completion, only looked at in REQ
//   dmem_rdata        read data, valid with dmem_ack
//   Regfile_weW, memToRegW, wirteRegAddrW, aluOutW, readDataW   MEM/WB register
//   bus_errW          sticky timeout flag (MEM_TIMEOUT_EN only)
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no access outstanding; ALU ops pass, memory ops are issued
// ST_REQ  | dmem_req held high, waiting for dmem_ack (or the watchdog)
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int DATA_W         = 32,
  parameter int REG_AW         = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Regfile_weM,
  input  logic              DataMem_weM,
  input  logic              memReadM,
  input  logic [REG_AW-1:0] wirteRegAddrM,
  input  logic [DATA_W-1:0] aluOutM,
  input  logic [DATA_W-1:0] writeDataM,
  output logic              stallM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              Regfile_weW,
  output logic              memToRegW,
  output logic [REG_AW-1:0] wirteRegAddrW,
  output logic [DATA_W-1:0] aluOutW,
`ifdef MEM_TIMEOUT_EN
  output logic              bus_errW,
`endif
  output logic [DATA_W-1:0] readDataW
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_op;
  logic w_is_load;
  logic w_issue;
  logic w_pass;
  logic w_done;
  logic w_timeout;

  assign w_op      = memReadM | DataMem_weM;
  // A load with the store bit also set is treated as a store.
  assign w_is_load = memReadM & ~DataMem_weM;

`ifdef MEM_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMR_W-1:0] r_tmr;
  logic             w_tmr_tc;

  // Down-counter loaded on issue. Terminal count marks the last allowed REQ cycle.
  assign w_tmr_tc = (r_tmr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmr    <= '0;
      bus_errW <= 1'b0;
    end else begin
      if (w_issue) begin
        r_tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
      end else if ((r_state == ST_REQ) && !w_tmr_tc) begin
        r_tmr <= r_tmr - 1'b1;
      end
      if (w_timeout) begin
        bus_errW <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stallM      = 1'b0;
    w_issue     = 1'b0;
    w_pass      = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_op) begin
          stallM      = 1'b1;
          w_issue     = 1'b1;
          w_state_nxt = ST_REQ;
        end else begin
          w_pass = 1'b1;
        end
      end
      ST_REQ: begin
        // An ack in the same cycle as the watchdog expiry wins.
        if (dmem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
`ifdef MEM_TIMEOUT_EN
        end else if (w_tmr_tc) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
`endif
        end else begin
          stallM = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      Regfile_weW   <= 1'b0;
      memToRegW     <= 1'b0;
      wirteRegAddrW <= '0;
      aluOutW       <= '0;
      readDataW     <= '0;
    end else begin
      // Bus request fields are captured only on issue and held through REQ.
      if (w_issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= DataMem_weM;
        dmem_addr  <= {aluOutM[DATA_W-1:2], 2'b00};
        dmem_wdata <= writeDataM;
      end else if (w_done || w_timeout) begin
        dmem_req <= 1'b0;
      end

      if (w_pass) begin
        Regfile_weW   <= Regfile_weM;
        memToRegW     <= 1'b0;
        wirteRegAddrW <= wirteRegAddrM;
        aluOutW       <= aluOutM;
      end else if (w_done) begin
        Regfile_weW   <= Regfile_weM & ~DataMem_weM;
        memToRegW     <= w_is_load;
        wirteRegAddrW <= wirteRegAddrM;
        aluOutW       <= aluOutM;
        if (w_is_load) begin
          readDataW <= dmem_rdata;
        end
      end else begin
        // Issue, wait and timeout cycles all push a bubble into MEM/WB.
        Regfile_weW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          Regfile_weM, DataMem_weM, memReadM;
  logic [AW-1:0] wirteRegAddrM;
  logic [DW-1:0] aluOutM, writeDataM;
  logic          stallM, dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic          Regfile_weW, memToRegW;
  logic [AW-1:0] wirteRegAddrW;
  logic [DW-1:0] aluOutW, readDataW;
  logic          bus_errW;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .Regfile_weM(Regfile_weM), .DataMem_weM(DataMem_weM), .memReadM(memReadM),
    .wirteRegAddrM(wirteRegAddrM), .aluOutM(aluOutM), .writeDataM(writeDataM),
    .stallM(stallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .Regfile_weW(Regfile_weW), .memToRegW(memToRegW),
    .wirteRegAddrW(wirteRegAddrW), .aluOutW(aluOutW),
`ifdef MEM_TIMEOUT_EN
    .bus_errW(bus_errW),
`endif
    .readDataW(readDataW)
  );

`ifndef MEM_TIMEOUT_EN
  assign bus_errW = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- responder ----------------
  bit            resp_en   = 1'b1;
  bit            force_ack = 1'b0;
  int            resp_wait = 0;
  int            resp_cnt  = 0;
  logic [DW-1:0] resp_data = '0;

  initial begin
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
  end

  always @(posedge clk) begin
    #1;
    if (resp_en && dmem_req) begin
      if (resp_cnt == resp_wait) begin
        dmem_ack   = 1'b1;
        dmem_rdata = resp_data;
        resp_cnt   = 0;
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        resp_cnt++;
      end
    end else begin
      dmem_ack   = force_ack;
      dmem_rdata = $urandom;
      resp_cnt   = 0;
    end
  end

  // ---------------- transaction-level model ----------------
  // m_busy: a bus transaction is outstanding; m_age: completed wait cycles of it.
  bit            m_live = 1'b0;
  bit            m_busy;
  int            m_age;
  logic          e_req, e_we, e_rfwe, e_m2r, e_err;
  logic [DW-1:0] e_addr, e_wdata, e_alu, e_rd;
  logic [AW-1:0] e_wa;

  always @(posedge clk) begin
    if (rst) begin
      m_live <= 1'b1;
      m_busy <= 1'b0;
      m_age  <= 0;
      e_req <= 0; e_we <= 0; e_addr <= 0; e_wdata <= 0;
      e_rfwe <= 0; e_m2r <= 0; e_wa <= 0; e_alu <= 0; e_rd <= 0; e_err <= 0;
    end else if (!m_busy) begin
      if (memReadM || DataMem_weM) begin
        e_req   <= 1'b1;
        e_we    <= DataMem_weM;
        e_addr  <= aluOutM & 32'hFFFF_FFFC;
        e_wdata <= writeDataM;
        e_rfwe  <= 1'b0;
        m_busy  <= 1'b1;
        m_age   <= 0;
      end else begin
        e_rfwe <= Regfile_weM;
        e_m2r  <= 1'b0;
        e_wa   <= wirteRegAddrM;
        e_alu  <= aluOutM;
      end
    end else begin
      m_age <= m_age + 1;
      if (dmem_ack) begin
        e_req  <= 1'b0;
        m_busy <= 1'b0;
        e_rfwe <= Regfile_weM && !DataMem_weM;
        e_m2r  <= memReadM && !DataMem_weM;
        e_wa   <= wirteRegAddrM;
        e_alu  <= aluOutM;
        if (memReadM && !DataMem_weM) e_rd <= dmem_rdata;
      end else if (TO_EN && (m_age + 1 == TO)) begin
        e_req  <= 1'b0;
        m_busy <= 1'b0;
        e_rfwe <= 1'b0;
        e_err  <= 1'b1;
      end else begin
        e_rfwe <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic e_stall;
    if (m_live) begin
      if (m_busy) e_stall = !dmem_ack && !(TO_EN && (m_age + 1 == TO));
      else        e_stall = memReadM || DataMem_weM;
      chk("stallM",        DW'(stallM),        DW'(e_stall));
      chk("dmem_req",      DW'(dmem_req),      DW'(e_req));
      chk("dmem_we",       DW'(dmem_we),       DW'(e_we));
      chk("dmem_addr",     dmem_addr,          e_addr);
      chk("dmem_wdata",    dmem_wdata,         e_wdata);
      chk("Regfile_weW",   DW'(Regfile_weW),   DW'(e_rfwe));
      chk("memToRegW",     DW'(memToRegW),     DW'(e_m2r));
      chk("wirteRegAddrW", DW'(wirteRegAddrW), DW'(e_wa));
      chk("aluOutW",       aluOutW,            e_alu);
      chk("readDataW",     readDataW,          e_rd);
      if (TO_EN) chk("bus_errW", DW'(bus_errW), DW'(e_err));
    end
  end

  // req pulse monitor: number of pulses and the low gap before the latest one
  int   mon_pulses = 0;
  int   mon_gap    = 0;
  int   mon_low    = 0;
  logic mon_prev   = 1'b0;

  always @(negedge clk) begin
    if (dmem_req === 1'b1) begin
      if (!mon_prev) begin
        mon_pulses++;
        mon_gap = mon_low;
      end
      mon_low = 0;
    end else begin
      mon_low++;
    end
    mon_prev = (dmem_req === 1'b1);
  end

  // ---------------- stimulus ----------------
  // Holds one instruction in MEM until the cycle in which stallM is low.
  task automatic run_instr(input logic rfwe, input logic st, input logic ld,
                           input logic [AW-1:0] wa, input logic [DW-1:0] alu,
                           input logic [DW-1:0] wd,
                           output int stalls, output int reqs,
                           output logic [DW-1:0] addr_seen, output logic we_seen);
    bit   done;
    logic s;
    Regfile_weM = rfwe; DataMem_weM = st; memReadM = ld;
    wirteRegAddrM = wa; aluOutM = alu; writeDataM = wd;
    stalls = 0; reqs = 0; addr_seen = '0; we_seen = 1'b0; done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      s = stallM;
      if (dmem_req) begin
        reqs++;
        addr_seen = dmem_addr;
        we_seen   = dmem_we;
      end
      if (s) stalls++;
      @(posedge clk);
      if (!s) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_instr: stall never released after 64 cycles (addr %h)", alu);
    end
    #1;
  endtask

  int            st_n, rq_n, pulses0;
  logic [DW-1:0] a_seen;
  logic          w_seen;

  initial begin
    rst = 1'b1;
    Regfile_weM = 0; DataMem_weM = 0; memReadM = 0;
    wirteRegAddrM = '0; aluOutM = '0; writeDataM = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset dmem_req", DW'(dmem_req), 32'd0);
    chk("reset Regfile_weW", DW'(Regfile_weW), 32'd0);
    chk("reset readDataW", readDataW, 32'd0);
    rst = 1'b0;

    // ALU pass-through
    run_instr(1, 0, 0, 5'd3, 32'h10, 32'h0, st_n, rq_n, a_seen, w_seen);
    chk("alu stalls", st_n, 0);
    chk("alu reqs", rq_n, 0);
    chk("alu Regfile_weW", DW'(Regfile_weW), 32'd1);
    chk("alu wirteRegAddrW", DW'(wirteRegAddrW), 32'd3);
    chk("alu aluOutW", aluOutW, 32'h10);
    chk("alu memToRegW", DW'(memToRegW), 32'd0);

    // zero-wait load
    resp_wait = 0; resp_data = 32'hDEADBEEF;
    run_instr(1, 0, 1, 5'd8, 32'h0000_0104, 32'h0, st_n, rq_n, a_seen, w_seen);
    chk("ld0 stalls", st_n, 1);
    chk("ld0 reqs", rq_n, 1);
    chk("ld0 addr", a_seen, 32'h104);
    chk("ld0 we", DW'(w_seen), 32'd0);
    chk("ld0 readDataW", readDataW, 32'hDEADBEEF);
    chk("ld0 memToRegW", DW'(memToRegW), 32'd1);
    chk("ld0 Regfile_weW", DW'(Regfile_weW), 32'd1);
    chk("ld0 wirteRegAddrW", DW'(wirteRegAddrW), 32'd8);

    // store, 3 wait states; Regfile_weM set to check the store masks it
    resp_wait = 3; resp_data = 32'h0BAD_0BAD;
    run_instr(1, 1, 0, 5'd4, 32'h203, 32'hA5A5_0001, st_n, rq_n, a_seen, w_seen);
    chk("st3 stalls", st_n, 4);
    chk("st3 reqs", rq_n, 4);
    chk("st3 addr", a_seen, 32'h200);
    chk("st3 we", DW'(w_seen), 32'd1);
    chk("st3 wdata", dmem_wdata, 32'hA5A5_0001);
    chk("st3 Regfile_weW", DW'(Regfile_weW), 32'd0);
    chk("st3 readDataW held", readDataW, 32'hDEADBEEF);

    // back-to-back load then store
    resp_wait = 0; resp_data = 32'h1234_5678;
    pulses0 = mon_pulses;
    run_instr(1, 0, 1, 5'd9, 32'h308, 32'h0, st_n, rq_n, a_seen, w_seen);
    chk("b2b ld readDataW", readDataW, 32'h1234_5678);
    chk("b2b ld wirteRegAddrW", DW'(wirteRegAddrW), 32'd9);
    run_instr(0, 1, 0, 5'd0, 32'h30C, 32'h55, st_n, rq_n, a_seen, w_seen);
    chk("b2b pulses", mon_pulses - pulses0, 2);
    chk("b2b gap", mon_gap, 1);
    chk("b2b st addr", a_seen, 32'h30C);
    chk("b2b readDataW held", readDataW, 32'h1234_5678);

    // load and store both set: treated as a store
    resp_wait = 1; resp_data = 32'hFFFF_FFFF;
    run_instr(1, 1, 1, 5'd12, 32'h410, 32'h77, st_n, rq_n, a_seen, w_seen);
    chk("both stalls", st_n, 2);
    chk("both we", DW'(w_seen), 32'd1);
    chk("both memToRegW", DW'(memToRegW), 32'd0);
    chk("both Regfile_weW", DW'(Regfile_weW), 32'd0);

`ifndef MEM_TIMEOUT_EN
    // without the watchdog a long wait simply completes
    resp_wait = 20; resp_data = 32'hCAFE_F00D;
    run_instr(1, 0, 1, 5'd13, 32'h500, 32'h0, st_n, rq_n, a_seen, w_seen);
    chk("long stalls", st_n, 21);
    chk("long readDataW", readDataW, 32'hCAFE_F00D);
`endif

    // reset mid-REQ, then a late ack
    resp_en = 1'b0; force_ack = 1'b0; resp_data = 32'hBAD0_BAD0;
    Regfile_weM = 1; DataMem_weM = 0; memReadM = 1;
    wirteRegAddrM = 5'd10; aluOutM = 32'h400; writeDataM = 0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid req high", DW'(dmem_req), 32'd1);
    rst = 1'b1;
    Regfile_weM = 0; memReadM = 0; wirteRegAddrM = 0; aluOutM = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst dmem_req", DW'(dmem_req), 32'd0);
    chk("rst dmem_addr", dmem_addr, 32'd0);
    chk("rst readDataW", readDataW, 32'd0);
    chk("rst aluOutW", aluOutW, 32'd0);
    force_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    force_ack = 1'b0;
    chk("late ack Regfile_weW", DW'(Regfile_weW), 32'd0);
    chk("late ack readDataW", readDataW, 32'd0);
    chk("late ack dmem_req", DW'(dmem_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // responder never acks: watchdog expires after TO request cycles
    resp_en = 1'b0;
    run_instr(1, 0, 1, 5'd11, 32'h600, 32'h0, st_n, rq_n, a_seen, w_seen);
    chk("to stalls", st_n, 4);
    chk("to reqs", rq_n, 4);
    chk("to bus_errW", DW'(bus_errW), 32'd1);
    chk("to Regfile_weW", DW'(Regfile_weW), 32'd0);
    resp_en = 1'b1;
    run_instr(1, 0, 0, 5'd2, 32'h20, 32'h0, st_n, rq_n, a_seen, w_seen);
    chk("to sticky bus_errW", DW'(bus_errW), 32'd1);
    chk("to alu Regfile_weW", DW'(Regfile_weW), 32'd1);
`endif

    resp_en = 1'b1;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
